// File: rtl/hamming_decoder.sv
// hamming_decoder: SECDED decode of a right-aligned 8/16/32-bit codeword into right-aligned data.
// Latency: out_valid rises 2 cycles after accept; sustains one word per cycle.
// Backpressure: stages advance only into an empty or draining slot; outputs hold while out_valid & !out_ready.
//
// Optional build macro HAMMING_DEC_STATS_EN: when defined, clr_cnt/corr_cnt/uncorr_cnt
// are live saturating counters; when undefined the counters read 0 and clr_cnt is ignored.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake for DATA_IN + CODEWORD_WIDTH
//   DATA_IN, CODEWORD_WIDTH  codeword (right-aligned) and size: 0=8b, 1=16b, 2/3=32b
//   out_valid/out_ready      output handshake for DATA_OUT + NUM_OF_ERRORS
//   DATA_OUT, NUM_OF_ERRORS  corrected data (zero-padded), 0=clean 1=corrected 2=uncorrectable
//   clr_cnt, corr_cnt, uncorr_cnt   statistics clear and counts
//
// Codeword layout for r Hamming bits (r=3/4/5): bits [r-1:0] are the Hamming checks,
// bit [r] is the overall parity, data sits above it. Data bit k occupies the k-th
// non-power-of-two position of the classic Hamming numbering, so its syndrome column
// is that position in the low r bits plus the overall-parity coverage in bit r.

module hamming_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int AMBA_WORD  = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AMBA_WORD-1:0] DATA_IN,
   input  logic [1:0]           CODEWORD_WIDTH,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AMBA_WORD-1:0] DATA_OUT,
   output logic [1:0]           NUM_OF_ERRORS,
   input  logic                 clr_cnt,
   output logic [CNT_WIDTH-1:0] corr_cnt,
   output logic [CNT_WIDTH-1:0] uncorr_cnt
);

   localparam int LDATA = DATA_WIDTH - 6;   // data bits carried by a Large codeword
   localparam int SYN_W = 6;                // widest syndrome (Large: 5 Hamming + overall)

   // Syndrome column of data bit k for a code with r Hamming bits. Only ever called
   // with constant arguments inside unrolled loops, so it folds to constants.
   function automatic logic [SYN_W-1:0] hcol(input int r, input int k);
      logic [SYN_W-1:0] col;
      int               cnt;
      col = '0;
      cnt = 0;
      for (int pos = 3; pos < 32; pos++) begin
         if (((pos & (pos - 1)) != 0) && (pos < (1 << r))) begin
            if (cnt == k) begin
               col    = SYN_W'(pos);
               // overall parity covers the data bit plus every Hamming check that covers it
               col[r] = ~^col[4:0];
            end
            cnt++;
         end
      end
      return col;
   endfunction

   // ---------------- stage 1: split fields and form the syndrome ----------------
   logic [1:0]       w_in;
   logic [LDATA-1:0] data_in_f;
   logic [SYN_W-1:0] pc;
   logic [SYN_W-1:0] syn_in;

   always_comb begin
      w_in      = (CODEWORD_WIDTH == 2'd3) ? 2'd2 : CODEWORD_WIDTH;
      data_in_f = '0;
      pc        = '0;
      syn_in    = '0;
      case (w_in)
         2'd0: begin
            data_in_f[3:0] = DATA_IN[7:4];
            for (int k = 0; k < 4; k++)
               if (DATA_IN[4+k]) pc ^= hcol(3, k);
            syn_in = {2'b00, DATA_IN[3:0]} ^ pc;
         end
         2'd1: begin
            data_in_f[10:0] = DATA_IN[15:5];
            for (int k = 0; k < 11; k++)
               if (DATA_IN[5+k]) pc ^= hcol(4, k);
            syn_in = {1'b0, DATA_IN[4:0]} ^ pc;
         end
         default: begin
            data_in_f = DATA_IN[LDATA+5:6];
            for (int k = 0; k < LDATA; k++)
               if (DATA_IN[6+k]) pc ^= hcol(5, k);
            syn_in = DATA_IN[5:0] ^ pc;
         end
      endcase
   end

   logic             s1_valid;
   logic [1:0]       s1_w;
   logic [LDATA-1:0] s1_data;
   logic [SYN_W-1:0] s1_syn;

   logic accept;
   logic s2_adv;

   assign s2_adv   = !out_valid | out_ready;
   assign in_ready = !(s1_valid & out_valid & !out_ready);
   assign accept   = in_valid & in_ready;

   // ---------------- stage 2: classify syndrome and correct ----------------
   logic [LDATA-1:0] fix_data;
   logic [1:0]       fix_nerr;
   logic [SYN_W-1:0] col;
   logic             hit;

   always_comb begin
      fix_data = s1_data;
      fix_nerr = 2'd0;
      col      = '0;
      hit      = 1'b0;
      if (s1_syn != '0) begin
         // columns beyond the word's data count come back as zero and never match
         for (int k = 0; k < LDATA; k++) begin
            case (s1_w)
               2'd0:    col = hcol(3, k);
               2'd1:    col = hcol(4, k);
               default: col = hcol(5, k);
            endcase
            if (col == s1_syn) begin
               fix_data[k] = ~s1_data[k];
               hit         = 1'b1;
            end
         end
         // a unit syndrome is a flipped check bit: data is already correct
         if (((s1_syn & (s1_syn - SYN_W'(1))) == '0) || hit)
            fix_nerr = 2'd1;
         else
            fix_nerr = 2'd2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_w          <= 2'd0;
         s1_data       <= '0;
         s1_syn        <= '0;
         out_valid     <= 1'b0;
         DATA_OUT      <= '0;
         NUM_OF_ERRORS <= 2'd0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_w     <= w_in;
            s1_data  <= data_in_f;
            s1_syn   <= syn_in;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               DATA_OUT      <= {{(AMBA_WORD-LDATA){1'b0}}, fix_data};
               NUM_OF_ERRORS <= fix_nerr;
            end
         end
      end
   end

   // ---------------- statistics ----------------
`ifdef HAMMING_DEC_STATS_EN
   logic out_fire;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (clr_cnt) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (out_fire) begin
         if ((NUM_OF_ERRORS == 2'd1) && (corr_cnt != '1))
            corr_cnt <= corr_cnt + CNT_WIDTH'(1);
         if ((NUM_OF_ERRORS == 2'd2) && (uncorr_cnt != '1))
            uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
      end
   end
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign corr_cnt       = '0;
   assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: directed and randomized checking of hamming_decoder against a
// positional SECDED model (classic Hamming numbering, overall parity on top).
// Counters are instantiated narrow so that saturation is reached in a few dozen words.

module tb_hamming_decoder;

   localparam int AW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] DATA_IN;
   logic [1:0]    CODEWORD_WIDTH;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] DATA_OUT;
   logic [1:0]    NUM_OF_ERRORS;
   logic          clr_cnt;
   logic [CW-1:0] corr_cnt;
   logic [CW-1:0] uncorr_cnt;

   hamming_decoder #(.DATA_WIDTH(32), .AMBA_WORD(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .DATA_IN(DATA_IN), .CODEWORD_WIDTH(CODEWORD_WIDTH),
      .out_valid(out_valid), .out_ready(out_ready),
      .DATA_OUT(DATA_OUT), .NUM_OF_ERRORS(NUM_OF_ERRORS),
      .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rbits(input logic [1:0] w);
      return (w == 2'd0) ? 3 : (w == 2'd1) ? 4 : 5;
   endfunction

   function automatic logic [31:0] enc(input logic [31:0] d, input logic [1:0] w);
      int          r;
      int          n;
      int          k;
      int          p;
      logic        ov;
      logic [31:0] cw;
      r  = rbits(w);
      n  = (1 << r) - 1;
      k  = 0;
      p  = 0;
      ov = 1'b0;
      cw = '0;
      for (int pos = 1; pos <= n; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) begin
               p  = p ^ pos;
               ov = ~ov;
            end
            cw[r+1+k] = d[k];
            k++;
         end
      end
      for (int i = 0; i < r; i++) begin
         cw[i] = p[i];
         ov    = ov ^ p[i];
      end
      cw[r] = ov;
      return cw;
   endfunction

   // returns {nerr, data}
   function automatic logic [33:0] dec(input logic [31:0] cw, input logic [1:0] w);
      int          r;
      int          n;
      int          k;
      int          pi;
      int          s;
      int          po;
      int          kat [32];
      logic [31:0] d;
      logic        b;
      r  = rbits(w);
      n  = (1 << r) - 1;
      k  = 0;
      pi = 0;
      s  = 0;
      po = 0;
      d  = '0;
      for (int i = 0; i < 32; i++) kat[i] = 0;
      for (int pos = 1; pos <= n; pos++) begin
         if ((pos & (pos - 1)) == 0) begin
            b = cw[pi];
            pi++;
         end else begin
            b        = cw[r+1+k];
            d[k]     = b;
            kat[pos] = k;
            k++;
         end
         if (b) begin
            s  = s ^ pos;
            po = po ^ 1;
         end
      end
      if (cw[r]) po = po ^ 1;
      if (s == 0 && po == 0) return {2'd0, d};
      if (po == 1) begin
         if (s != 0 && (s & (s - 1)) != 0) d[kat[s]] = ~d[kat[s]];
         return {2'd1, d};
      end
      return {2'd2, d};
   endfunction

   // Random data word of width w with e injected bit errors and junk above the codeword.
   task automatic make_word(input logic [1:0] w, input int e,
                            output logic [31:0] cw, output logic [33:0] ex);
      int          nb;
      int          nd;
      int          i1;
      int          i2;
      logic [31:0] d;
      nb = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
      nd = nb - rbits(w) - 1;
      d  = $urandom & ((32'd1 << nd) - 32'd1);
      cw = enc(d, w);
      i1 = $urandom_range(0, nb - 1);
      i2 = $urandom_range(0, nb - 1);
      while (i2 == i1) i2 = $urandom_range(0, nb - 1);
      if (e >= 1) cw[i1] = ~cw[i1];
      if (e == 2) cw[i2] = ~cw[i2];
      ex = dec(cw, w);
      check("model nerr", {30'd0, ex[33:32]}, 32'(e));
      if (e < 2) check("model data", ex[31:0], d);
      if (nb < 32) cw = cw | ($urandom << nb);
   endtask

   // ---------------- output readiness generator ----------------
   int out_mode = 1;   // 0: stall, 1: always ready, 2: random
   always @(posedge clk) begin
      #2;
      case (out_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // ---------------- scoreboard / compare process ----------------
   logic [33:0] expq [$];
   logic [33:0] nxt_exp;
   logic [33:0] e_pop;
   int          m_corr   = 0;
   int          m_uncorr = 0;
   logic        hold_vld = 1'b0;
   logic [31:0] hold_dat;
   logic [1:0]  hold_num;
   logic        fire;
   localparam int CMAX = (1 << CW) - 1;

   always @(negedge clk) begin
      if (rst) begin
         expq.delete();
         m_corr   = 0;
         m_uncorr = 0;
         hold_vld = 1'b0;
      end else begin
`ifdef HAMMING_DEC_STATS_EN
         check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
         check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
`else
         check("corr_cnt tied", 32'(corr_cnt), 32'd0);
         check("uncorr_cnt tied", 32'(uncorr_cnt), 32'd0);
`endif
         if (hold_vld) begin
            check("hold out_valid", {31'd0, out_valid}, 32'd1);
            check("hold DATA_OUT", DATA_OUT, hold_dat);
            check("hold NUM_OF_ERRORS", {30'd0, NUM_OF_ERRORS}, {30'd0, hold_num});
         end
         fire  = 1'b0;
         e_pop = '0;
         if (out_valid) begin
            if (expq.size() == 0) begin
               check("unexpected out_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_ready) begin
               e_pop = expq.pop_front();
               fire  = 1'b1;
               check("DATA_OUT", DATA_OUT, e_pop[31:0]);
               check("NUM_OF_ERRORS", {30'd0, NUM_OF_ERRORS}, {30'd0, e_pop[33:32]});
            end
         end
         hold_vld = out_valid & !out_ready;
         hold_dat = DATA_OUT;
         hold_num = NUM_OF_ERRORS;
         if (clr_cnt) begin
            m_corr   = 0;
            m_uncorr = 0;
         end else if (fire) begin
            if (e_pop[33:32] == 2'd1 && m_corr < CMAX) m_corr++;
            if (e_pop[33:32] == 2'd2 && m_uncorr < CMAX) m_uncorr++;
         end
         if (in_valid && in_ready) expq.push_back(nxt_exp);
      end
   end

   // ---------------- driver ----------------
   task automatic push_word(input logic [31:0] d, input logic [1:0] w, input logic [33:0] e);
      int t;
      t              = 0;
      DATA_IN        = d;
      CODEWORD_WIDTH = w;
      nxt_exp        = e;
      in_valid       = 1'b1;
      @(negedge clk);
      while (!in_ready) begin
         t++;
         if (t > 200) begin
            check("accept timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] cw;
   logic [33:0] ex;

   initial begin
      rst            = 1'b1;
      in_valid       = 1'b0;
      DATA_IN        = '0;
      CODEWORD_WIDTH = 2'd0;
      clr_cnt        = 1'b0;
      nxt_exp        = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset DATA_OUT", DATA_OUT, 32'd0);
      check("reset NUM_OF_ERRORS", {30'd0, NUM_OF_ERRORS}, 32'd0);
      check("reset corr_cnt", 32'(corr_cnt), 32'd0);
      check("reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready after reset", {31'd0, in_ready}, 32'd1);

      // pin the model to hand-computed Small words
      check("model enc 0xB", enc(32'hB, 2'd0), 32'hB1);
      ex = dec(32'h31, 2'd0);
      check("model dec 0x31", {ex[33:32], ex[29:0]}, {2'd1, 30'hB});
      ex = dec(32'h71, 2'd0);
      check("model dec 0x71", {ex[33:32], ex[29:0]}, {2'd2, 30'h7});
      @(posedge clk);
      #1;

      // directed Small words with literal expectations, latency on the first
      push_word(32'h000000B1, 2'd0, {2'd0, 32'h0000000B});
      in_valid = 1'b0;
      @(negedge clk);
      check("latency cycle1 out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("latency cycle2 out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      push_word(32'h00000031, 2'd0, {2'd1, 32'h0000000B});
      push_word(32'h000000B0, 2'd0, {2'd1, 32'h0000000B});
      push_word(32'h00000071, 2'd0, {2'd2, 32'h00000007});
      drain(5);
`ifdef HAMMING_DEC_STATS_EN
      check("directed corr_cnt", 32'(corr_cnt), 32'd2);
      check("directed uncorr_cnt", 32'(uncorr_cnt), 32'd1);
`endif

      // backpressure: four mixed-width words while the output stalls for 5 cycles
      out_mode = 0;
      fork
         begin
            make_word(2'd0, 1, cw, ex); push_word(cw, 2'd0, ex);
            make_word(2'd1, 0, cw, ex); push_word(cw, 2'd1, ex);
            make_word(2'd2, 2, cw, ex); push_word(cw, 2'd2, ex);
            make_word(2'd3, 1, cw, ex); push_word(cw, 2'd3, ex);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            check("bp in_ready after 2 accepts", {31'd0, in_ready}, 32'd0);
            repeat (3) @(posedge clk);
            #1 out_mode = 1;
         end
      join
      drain(8);
      check("bp all words out", 32'(expq.size()), 32'd0);

`ifdef HAMMING_DEC_STATS_EN
      // saturation, then clear colliding with increments
      repeat (CMAX + 4) begin
         make_word(2'd1, 1, cw, ex);
         push_word(cw, 2'd1, ex);
      end
      repeat (CMAX + 4) begin
         make_word(2'd2, 2, cw, ex);
         push_word(cw, 2'd2, ex);
      end
      drain(5);
      check("corr_cnt saturated", 32'(corr_cnt), 32'(CMAX));
      check("uncorr_cnt saturated", 32'(uncorr_cnt), 32'(CMAX));
      clr_cnt = 1'b1;
      repeat (6) begin
         make_word(2'd0, 1, cw, ex);
         push_word(cw, 2'd0, ex);
      end
      drain(4);
      check("clr beats increment", 32'(corr_cnt), 32'd0);
      clr_cnt = 1'b0;
      make_word(2'd0, 1, cw, ex);
      push_word(cw, 2'd0, ex);
      drain(4);
      check("count after clear", 32'(corr_cnt), 32'd1);
`endif

      // reset with two words in flight
      out_mode = 0;
      make_word(2'd1, 1, cw, ex); push_word(cw, 2'd1, ex);
      make_word(2'd2, 2, cw, ex); push_word(cw, 2'd2, ex);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
      check("mid reset DATA_OUT", DATA_OUT, 32'd0);
      check("mid reset corr_cnt", 32'(corr_cnt), 32'd0);
      check("mid reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_mode = 1;
      @(negedge clk);
      check("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("no stale word", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      push_word(32'h000000B1, 2'd0, {2'd0, 32'h0000000B});
      drain(4);

      // randomized traffic with random stalls, gaps and clears
      out_mode = 2;
      for (int i = 0; i < 600; i++) begin
         logic [1:0] w;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         clr_cnt = ($urandom_range(0, 15) == 0);
         w       = 2'($urandom_range(0, 3));
         make_word(w, $urandom_range(0, 2), cw, ex);
         push_word(cw, w, ex);
      end
      clr_cnt  = 1'b0;
      out_mode = 1;
      drain(10);
      check("random all words out", 32'(expq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
